// File: rtl/e203_fpu_pkg.sv
// Shared definitions for the FPU misc writeback slice: source encodings,
// register-index width and the tag carried with every writeback entry.
package e203_fpu_pkg;

  localparam int unsigned RFIDX_W    = 5;
  localparam int unsigned FMIS_XLEN  = 32;
  localparam int unsigned WBCK_TAG_W = RFIDX_W + 1;

  typedef enum logic [1:0] {
    FMIS_SRC_SGNJ = 2'd0,
    FMIS_SRC_MM   = 2'd1,
    FMIS_SRC_CLS  = 2'd2
  } fmis_src_e;

  typedef struct packed {
    logic [RFIDX_W-1:0] rdidx;
    logic               rdfpu;
  } wbck_tag_t;

  // Entry layout is {wdat, rdidx, rdfpu}, i.e. xlen + 6 bits.
  function automatic int unsigned wbck_ent_w(input int unsigned xlen);
    return xlen + WBCK_TAG_W;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_fmis_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with flush and occupancy output.
// DEPTH must be a power of two so the pointers wrap naturally.
module e203_exu_fpu_fmis_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 38
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             pdat_i,
  input  logic                         pop_i,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [WIDTH-1:0]             rdat_o,
  output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_ok, pop_ok;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == OCC_W'(DEPTH));
  assign rdat_o  = mem_q[rd_ptr_q];
  assign occ_o   = occ_q;

  always_comb begin
    push_ok  = push_i && !full_o;
    pop_ok   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    // Flush wins over any same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      if (push_ok && !flush) mem_q[wr_ptr_q] <= pdat_i;
    end
  end

endmodule

// File: rtl/e203_exu_fpu_fmis_wbck.sv
// FPU misc writeback: fixed-priority arbitration of sgnj/mm/cls results,
// tagging with the destination register, FIFO buffering and in-order output.
// Optional zero-latency empty-FIFO bypass: E203_FMIS_WBCK_BYPASS_EN.
module e203_exu_fpu_fmis_wbck
  import e203_fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned XLEN  = FMIS_XLEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        sgnj_i_valid,
  output logic                        sgnj_i_ready,
  input  logic [XLEN-1:0]             sgnj_i_wdat,
  input  logic                        mm_i_valid,
  output logic                        mm_i_ready,
  input  logic [XLEN-1:0]             mm_i_wdat,
  input  logic                        cls_i_valid,
  output logic                        cls_i_ready,
  input  logic [XLEN-1:0]             cls_i_wdat,
  input  logic [RFIDX_W-1:0]          i_rdidx,
  input  logic                        i_rdfpu,
  output logic                        wbck_o_valid,
  input  logic                        wbck_o_ready,
  output logic [XLEN-1:0]             wbck_o_wdat,
  output logic [RFIDX_W-1:0]          wbck_o_rdidx,
  output logic                        wbck_o_rdfpu,
  output logic [$clog2(DEPTH+1)-1:0]  occ
);

  localparam int unsigned ENT_W = wbck_ent_w(XLEN);

  fmis_src_e        win_src;
  logic             win_vld;
  logic             win_rdy;
  logic [XLEN-1:0]  win_dat;
  wbck_tag_t        win_tag;
  wbck_tag_t        out_tag;
  logic             byp;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ENT_W-1:0] fifo_rdat;

  // Fixed priority sgnj > mm > cls; losers hold their valid/data.
  always_comb begin
    win_src = FMIS_SRC_SGNJ;
    win_vld = 1'b0;
    win_dat = '0;
    if (sgnj_i_valid) begin
      win_src = FMIS_SRC_SGNJ;
      win_vld = 1'b1;
      win_dat = sgnj_i_wdat;
    end else if (mm_i_valid) begin
      win_src = FMIS_SRC_MM;
      win_vld = 1'b1;
      win_dat = mm_i_wdat;
    end else if (cls_i_valid) begin
      win_src = FMIS_SRC_CLS;
      win_vld = 1'b1;
      win_dat = cls_i_wdat;
    end
  end

  assign win_tag = '{rdidx: i_rdidx, rdfpu: i_rdfpu};

`ifdef E203_FMIS_WBCK_BYPASS_EN
  assign win_rdy = !rst && !flush &&
                   (fifo_empty ? (!fifo_full || wbck_o_ready) : !fifo_full);
  // Bypass only from an empty FIFO, so ordering is never disturbed.
  assign byp     = fifo_empty && wbck_o_ready && win_vld && win_rdy;
`else
  assign win_rdy = !rst && !flush && !fifo_full;
  assign byp     = 1'b0;
`endif

  assign sgnj_i_ready = win_rdy && (win_src == FMIS_SRC_SGNJ);
  assign mm_i_ready   = win_rdy && (win_src == FMIS_SRC_MM);
  assign cls_i_ready  = win_rdy && (win_src == FMIS_SRC_CLS);
  assign fifo_push    = win_vld && win_rdy && !byp;

  e203_exu_fpu_fmis_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push_i  (fifo_push),
    .pdat_i  ({win_dat, win_tag}),
    .pop_i   (wbck_o_ready),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .rdat_o  (fifo_rdat),
    .occ_o   (occ)
  );

  always_comb begin
    wbck_o_valid           = !fifo_empty;
    {wbck_o_wdat, out_tag} = fifo_rdat;
    if (byp) begin
      wbck_o_valid = 1'b1;
      wbck_o_wdat  = win_dat;
      out_tag      = win_tag;
    end
    wbck_o_rdidx = out_tag.rdidx;
    wbck_o_rdfpu = out_tag.rdfpu;
  end

endmodule

// File: tb/tb_e203_exu_fpu_fmis_wbck.sv
// Directed bench for the FPU misc writeback stage; expected results are
// queued at acceptance and checked by an independent output monitor.
module tb_e203_exu_fpu_fmis_wbck;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              sgnj_i_valid, sgnj_i_ready;
  logic [XLEN-1:0]   sgnj_i_wdat;
  logic              mm_i_valid, mm_i_ready;
  logic [XLEN-1:0]   mm_i_wdat;
  logic              cls_i_valid, cls_i_ready;
  logic [XLEN-1:0]   cls_i_wdat;
  logic [4:0]        i_rdidx;
  logic              i_rdfpu;
  logic              wbck_o_valid;
  logic              wbck_o_ready;
  logic [XLEN-1:0]   wbck_o_wdat;
  logic [4:0]        wbck_o_rdidx;
  logic              wbck_o_rdfpu;
  logic [1:0]        occ;

  typedef struct packed {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        rdfpu;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_fmis_wbck #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .sgnj_i_valid (sgnj_i_valid),
    .sgnj_i_ready (sgnj_i_ready),
    .sgnj_i_wdat  (sgnj_i_wdat),
    .mm_i_valid   (mm_i_valid),
    .mm_i_ready   (mm_i_ready),
    .mm_i_wdat    (mm_i_wdat),
    .cls_i_valid  (cls_i_valid),
    .cls_i_ready  (cls_i_ready),
    .cls_i_wdat   (cls_i_wdat),
    .i_rdidx      (i_rdidx),
    .i_rdfpu      (i_rdfpu),
    .wbck_o_valid (wbck_o_valid),
    .wbck_o_ready (wbck_o_ready),
    .wbck_o_wdat  (wbck_o_wdat),
    .wbck_o_rdidx (wbck_o_rdidx),
    .wbck_o_rdfpu (wbck_o_rdfpu),
    .occ          (occ)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] d, input logic [4:0] idx, input logic fpu);
    exp_q.push_back('{wdat: d, rdidx: idx, rdfpu: fpu});
  endtask

  // Output monitor: every completed writeback handshake is checked in order.
  always @(negedge clk) begin
    if (!rst && wbck_o_valid === 1'b1 && wbck_o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL wbck_unexpected: got 0x%0h expected none", wbck_o_wdat);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wbck_wdat",  64'(wbck_o_wdat),  64'(mon_e.wdat));
        chk("wbck_rdidx", 64'(wbck_o_rdidx), 64'(mon_e.rdidx));
        chk("wbck_rdfpu", 64'(wbck_o_rdfpu), 64'(mon_e.rdfpu));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wbck_o_ready = 1'b0;
    sgnj_i_valid = 1'b1; sgnj_i_wdat = 32'hDEAD;
    mm_i_valid = 1'b0; mm_i_wdat = '0;
    cls_i_valid = 1'b0; cls_i_wdat = '0;
    i_rdidx = '0; i_rdfpu = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_sgnj_ready", 64'(sgnj_i_ready), 64'd0);
    step();
    rst = 1'b0; sgnj_i_valid = 1'b0;
    @(negedge clk);
    chk("rst_occ",   64'(occ),          64'd0);
    chk("rst_valid", 64'(wbck_o_valid), 64'd0);
    chk("rst_wdat",  64'(wbck_o_wdat),  64'd0);
    chk("rst_rdidx", 64'(wbck_o_rdidx), 64'd0);
    chk("rst_rdfpu", 64'(wbck_o_rdfpu), 64'd0);

`ifdef E203_FMIS_WBCK_BYPASS_EN
    // Bypass: empty FIFO and ready output pass the result in the same cycle.
    step();
    wbck_o_ready = 1'b1;
    cls_i_valid = 1'b1; cls_i_wdat = 32'h200; i_rdidx = 5'd2; i_rdfpu = 1'b0;
    expect_out(32'h200, 5'd2, 1'b0);
    @(negedge clk);
    chk("byp_cls_ready", 64'(cls_i_ready),  64'd1);
    chk("byp_valid",     64'(wbck_o_valid), 64'd1);
    chk("byp_occ",       64'(occ),          64'd0);
    step();
    cls_i_valid = 1'b0;
    @(negedge clk);
    chk("byp_occ_after",   64'(occ),          64'd0);
    chk("byp_valid_after", 64'(wbck_o_valid), 64'd0);
`else
    // Single sgnj result, one-cycle latency.
    step();
    wbck_o_ready = 1'b1;
    sgnj_i_valid = 1'b1; sgnj_i_wdat = 32'h3F80_0000; i_rdidx = 5'd5; i_rdfpu = 1'b1;
    @(negedge clk);
    chk("t1_sgnj_ready", 64'(sgnj_i_ready), 64'd1);
    chk("t1_valid_pre",  64'(wbck_o_valid), 64'd0);
    expect_out(32'h3F80_0000, 5'd5, 1'b1);
    step();
    sgnj_i_valid = 1'b0;
    @(negedge clk);
    chk("t1_occ1",  64'(occ),          64'd1);
    chk("t1_valid", 64'(wbck_o_valid), 64'd1);
    step();
    @(negedge clk);
    chk("t1_occ0",       64'(occ),          64'd0);
    chk("t1_valid_done", 64'(wbck_o_valid), 64'd0);

    // sgnj beats cls; cls follows next cycle.
    step();
    sgnj_i_valid = 1'b1; sgnj_i_wdat = 32'h11; i_rdidx = 5'd1; i_rdfpu = 1'b0;
    cls_i_valid  = 1'b1; cls_i_wdat  = 32'h33;
    @(negedge clk);
    chk("t2_sgnj_ready", 64'(sgnj_i_ready), 64'd1);
    chk("t2_cls_ready",  64'(cls_i_ready),  64'd0);
    chk("t2_mm_ready",   64'(mm_i_ready),   64'd0);
    expect_out(32'h11, 5'd1, 1'b0);
    step();
    sgnj_i_valid = 1'b0; i_rdidx = 5'd3; i_rdfpu = 1'b1;
    @(negedge clk);
    chk("t2_cls_ready2", 64'(cls_i_ready), 64'd1);
    expect_out(32'h33, 5'd3, 1'b1);
    step();
    cls_i_valid = 1'b0;
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t2_occ0", 64'(occ), 64'd0);

    // Back-pressure: third push refused until a slot frees.
    step();
    wbck_o_ready = 1'b0;
    mm_i_valid = 1'b1; mm_i_wdat = 32'h101; i_rdidx = 5'd10; i_rdfpu = 1'b0;
    @(negedge clk);
    chk("t3_mm_ready1", 64'(mm_i_ready), 64'd1);
    expect_out(32'h101, 5'd10, 1'b0);
    step();
    mm_i_wdat = 32'h102; i_rdidx = 5'd11;
    @(negedge clk);
    chk("t3_mm_ready2", 64'(mm_i_ready), 64'd1);
    expect_out(32'h102, 5'd11, 1'b0);
    step();
    mm_i_wdat = 32'h103; i_rdidx = 5'd12;
    @(negedge clk);
    chk("t3_occ_full",   64'(occ),        64'd2);
    chk("t3_mm_ready3",  64'(mm_i_ready), 64'd0);
    step();
    @(negedge clk);
    chk("t3_mm_hold", 64'(mm_i_ready), 64'd0);
    step();
    wbck_o_ready = 1'b1;
    @(negedge clk);
    chk("t3_full_pop_ready", 64'(mm_i_ready), 64'd0);
    step();
    @(negedge clk);
    chk("t3_occ_after_pop", 64'(occ),        64'd1);
    chk("t3_mm_ready4",     64'(mm_i_ready), 64'd1);
    expect_out(32'h103, 5'd12, 1'b0);
    step();
    mm_i_valid = 1'b0;
    @(negedge clk);
    chk("t3_occ_pushpop", 64'(occ), 64'd1);
    step();
    @(negedge clk);
    chk("t3_occ0", 64'(occ), 64'd0);

    // Full with a pop, then a push: 2 -> 1 -> 2 across pointer wrap.
    step();
    wbck_o_ready = 1'b0;
    cls_i_valid = 1'b1; cls_i_wdat = 32'h201; i_rdidx = 5'd20; i_rdfpu = 1'b1;
    @(negedge clk);
    chk("t4_cls_ready1", 64'(cls_i_ready), 64'd1);
    expect_out(32'h201, 5'd20, 1'b1);
    step();
    cls_i_wdat = 32'h202; i_rdidx = 5'd21;
    @(negedge clk);
    chk("t4_cls_ready2", 64'(cls_i_ready), 64'd1);
    expect_out(32'h202, 5'd21, 1'b1);
    step();
    cls_i_valid = 1'b0; wbck_o_ready = 1'b1;
    @(negedge clk);
    chk("t4_occ2", 64'(occ), 64'd2);
    step();
    wbck_o_ready = 1'b0;
    cls_i_valid = 1'b1; cls_i_wdat = 32'h203; i_rdidx = 5'd22;
    @(negedge clk);
    chk("t4_occ1",       64'(occ),         64'd1);
    chk("t4_cls_ready3", 64'(cls_i_ready), 64'd1);
    expect_out(32'h203, 5'd22, 1'b1);
    step();
    cls_i_valid = 1'b0;
    @(negedge clk);
    chk("t4_occ2b", 64'(occ), 64'd2);
    step();
    wbck_o_ready = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t4_occ0",   64'(occ),          64'd0);
    chk("t4_valid0", 64'(wbck_o_valid), 64'd0);

    // Flush of a full FIFO drops the buffered results and the pending push.
    step();
    wbck_o_ready = 1'b0;
    sgnj_i_valid = 1'b1; sgnj_i_wdat = 32'h301; i_rdidx = 5'd30; i_rdfpu = 1'b0;
    @(negedge clk);
    chk("t5_sgnj_ready1", 64'(sgnj_i_ready), 64'd1);
    step();
    sgnj_i_wdat = 32'h302;
    @(negedge clk);
    chk("t5_sgnj_ready2", 64'(sgnj_i_ready), 64'd1);
    step();
    sgnj_i_valid = 1'b0;
    @(negedge clk);
    chk("t5_occ2", 64'(occ), 64'd2);
    step();
    flush = 1'b1; mm_i_valid = 1'b1; mm_i_wdat = 32'h399;
    @(negedge clk);
    chk("t5_mm_ready_flush", 64'(mm_i_ready),   64'd0);
    chk("t5_valid_preflush", 64'(wbck_o_valid), 64'd1);
    step();
    flush = 1'b0; mm_i_valid = 1'b0;
    @(negedge clk);
    chk("t5_occ_flushed",   64'(occ),          64'd0);
    chk("t5_valid_flushed", 64'(wbck_o_valid), 64'd0);
    step();
    wbck_o_ready = 1'b1;
    sgnj_i_valid = 1'b1; sgnj_i_wdat = 32'h3AA; i_rdidx = 5'd7; i_rdfpu = 1'b1;
    @(negedge clk);
    chk("t5_sgnj_ready3", 64'(sgnj_i_ready), 64'd1);
    expect_out(32'h3AA, 5'd7, 1'b1);
    step();
    sgnj_i_valid = 1'b0;
    @(negedge clk);
    step();
    flush = 1'b1; cls_i_valid = 1'b1; cls_i_wdat = 32'h3BB;
    @(negedge clk);
    chk("t5_cls_ready_flush", 64'(cls_i_ready), 64'd0);
    step();
    flush = 1'b0; cls_i_valid = 1'b0;
    @(negedge clk);
    chk("t5_occ_end",   64'(occ),          64'd0);
    chk("t5_valid_end", 64'(wbck_o_valid), 64'd0);
`endif

    step(); step();
    chk("exp_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
